// File: rtl/usr_pkg.sv
`default_nettype none
// ============================================================================
// Module      : usr_pkg
// Description : Shared op/select encoding and controller state encoding for
//               the universal shift register sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package usr_pkg;

    typedef enum logic [1:0] {
        OP_HOLD = 2'b00,
        OP_SHR  = 2'b01,
        OP_SHL  = 2'b10,
        OP_LOAD = 2'b11
    } op_e;

    typedef logic [1:0] state_t;

    localparam state_t C_ST_IDLE = 2'd0;
    localparam state_t C_ST_RUN  = 2'd1;
    localparam state_t C_ST_DONE = 2'd2;

endpackage
`default_nettype wire

// File: rtl/usr_core.sv
`default_nettype none
// ============================================================================
// Module      : usr_core
// Description : WIDTH-bit universal shift register (hold / shift right /
//               shift left / parallel load).
// Revision    : 1.0 - initial release
// ============================================================================
module usr_core
    import usr_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  op_e              sel,
    input  logic [WIDTH-1:0] par_in,
    input  logic             msb_in,
    input  logic             lsb_in,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else begin
            case (sel)
                OP_HOLD: q <= q;
                OP_SHR:  q <= {msb_in, q[WIDTH-1:1]};
                OP_SHL:  q <= {q[WIDTH-2:0], lsb_in};
                OP_LOAD: q <= par_in;
                default: q <= q;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/usr_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : usr_sequencer
// Description : Command-driven controller that runs hold/shift/rotate/load
//               jobs on an internal universal shift register.
// Revision    : 1.0 - initial release
// ============================================================================
module usr_sequencer
    import usr_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [CNT_W-1:0] cmd_cnt,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic             cmd_fill,
    input  logic             cmd_rot,
    output logic             busy,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             done,
    output logic [WIDTH-1:0] data_out
);

    state_t           r_state;
    op_e              r_op;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_data;
    logic             r_fill;
    logic             r_rot;

    op_e              w_sel;
    logic             w_msb_in;
    logic             w_lsb_in;
    logic             w_in_run;
    logic             w_ser;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= C_ST_IDLE;
            r_op    <= OP_HOLD;
            r_cnt   <= '0;
            r_data  <= '0;
            r_fill  <= 1'b0;
            r_rot   <= 1'b0;
        end else begin
            case (r_state)
                C_ST_IDLE: begin
                    if (cmd_valid) begin
                        r_op   <= op_e'(cmd_op);
                        r_cnt  <= cmd_cnt;
                        r_data <= cmd_data;
                        r_fill <= cmd_fill;
                        r_rot  <= cmd_rot;
                        // Zero-length hold/shift completes without touching the register
                        if (op_e'(cmd_op) == OP_LOAD || cmd_cnt != '0)
                            r_state <= C_ST_RUN;
                        else
                            r_state <= C_ST_DONE;
                    end
                end
                C_ST_RUN: begin
                    if (r_op == OP_LOAD || r_cnt == CNT_W'(1))
                        r_state <= C_ST_DONE;
                    else
                        r_cnt <= r_cnt - CNT_W'(1);
                end
                C_ST_DONE: r_state <= C_ST_IDLE;
                default:   r_state <= C_ST_IDLE;
            endcase
        end
    end

    assign w_in_run = (r_state == C_ST_RUN);
    assign w_sel    = w_in_run ? r_op : OP_HOLD;
    // Rotation feeds the outgoing bit back into the vacated end
    assign w_msb_in = r_rot ? data_out[0]       : r_fill;
    assign w_lsb_in = r_rot ? data_out[WIDTH-1] : r_fill;

    always_comb begin
        w_ser = 1'b0;
        if (w_in_run) begin
            if (r_op == OP_SHR)
                w_ser = data_out[0];
            else if (r_op == OP_SHL)
                w_ser = data_out[WIDTH-1];
        end
    end

    assign cmd_ready = (r_state == C_ST_IDLE);
    assign busy      = (r_state != C_ST_IDLE);
    assign done      = (r_state == C_ST_DONE);
    assign ser_valid = w_in_run && (r_op == OP_SHR || r_op == OP_SHL);
    assign ser_out   = w_ser;

    usr_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk    (clk),
        .rst    (rst),
        .sel    (w_sel),
        .par_in (r_data),
        .msb_in (w_msb_in),
        .lsb_in (w_lsb_in),
        .q      (data_out)
    );

endmodule
`default_nettype wire

// File: tb/tb_usr_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_usr_sequencer
// Description : Self-checking bench for usr_sequencer against an arithmetic
//               model of the register contents.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_usr_sequencer;

    localparam int WIDTH = 4;
    localparam int CNT_W = 3;
    localparam int MODV  = 1 << WIDTH;

    logic             clk;
    logic             rst;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [CNT_W-1:0] cmd_cnt;
    logic [WIDTH-1:0] cmd_data;
    logic             cmd_fill;
    logic             cmd_rot;
    logic             busy;
    logic             ser_out;
    logic             ser_valid;
    logic             done;
    logic [WIDTH-1:0] data_out;

    int n_cmp  = 0;
    int n_fail = 0;
    int m_val  = 0;

    usr_sequencer #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_cnt   (cmd_cnt),
        .cmd_data  (cmd_data),
        .cmd_fill  (cmd_fill),
        .cmd_rot   (cmd_rot),
        .busy      (busy),
        .ser_out   (ser_out),
        .ser_valid (ser_valid),
        .done      (done),
        .data_out  (data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Issue one command at a negedge and follow it cycle by cycle to completion
    task automatic run_cmd(input logic [1:0] op, input int cnt, input int data,
                           input logic fill, input logic rot, input bit repulse);
        int  run_cycles;
        int  fb;
        bit  shifting;
        chk("ready_before_cmd", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_cnt   = CNT_W'(cnt);
        cmd_data  = WIDTH'(data);
        cmd_fill  = fill;
        cmd_rot   = rot;
        next_cycle();
        if (repulse) begin
            cmd_op   = 2'($urandom_range(0, 3));
            cmd_cnt  = CNT_W'($urandom_range(0, 7));
            cmd_data = ~WIDTH'(data);
        end else begin
            cmd_valid = 1'b0;
        end
        run_cycles = (op == 2'b11) ? 1 : cnt;
        shifting   = (op == 2'b01 || op == 2'b10);
        for (int k = 0; k < run_cycles; k++) begin
            chk("run_busy", busy, 1);
            chk("run_ready", cmd_ready, 0);
            chk("run_done", done, 0);
            chk("run_ser_valid", ser_valid, 32'(shifting));
            chk("run_data", data_out, 32'(m_val));
            case (op)
                2'b01: begin
                    chk("ser_out_shr", ser_out, 32'(m_val % 2));
                    fb    = rot ? (m_val % 2) : int'(fill);
                    m_val = m_val / 2 + fb * (MODV / 2);
                end
                2'b10: begin
                    chk("ser_out_shl", ser_out, 32'(m_val / (MODV / 2)));
                    fb    = rot ? (m_val / (MODV / 2)) : int'(fill);
                    m_val = (m_val * 2) % MODV + fb;
                end
                2'b11: begin
                    chk("ser_out_load", ser_out, 0);
                    m_val = data % MODV;
                end
                default: chk("ser_out_hold", ser_out, 0);
            endcase
            next_cycle();
            cmd_valid = 1'b0;
        end
        chk("done_pulse", done, 1);
        chk("done_busy", busy, 1);
        chk("done_ready", cmd_ready, 0);
        chk("done_ser_valid", ser_valid, 0);
        chk("done_data", data_out, 32'(m_val));
        next_cycle();
        chk("after_ready", cmd_ready, 1);
        chk("after_busy", busy, 0);
        chk("after_done", done, 0);
        chk("after_data", data_out, 32'(m_val));
    endtask

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_cnt   = '0;
        cmd_data  = '0;
        cmd_fill  = 1'b0;
        cmd_rot   = 1'b0;
        @(negedge clk);
        next_cycle();
        rst = 1'b0;
        chk("rst_data", data_out, 0);
        chk("rst_ready", cmd_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ser_valid", ser_valid, 0);
        chk("rst_ser_out", ser_out, 0);

        run_cmd(2'b11, 0, 4'b1011, 1'b0, 1'b0, 1'b0);
        chk("load_value", data_out, 4'b1011);
        run_cmd(2'b01, 2, 0, 1'b1, 1'b0, 1'b0);
        chk("shr_fill1_value", data_out, 4'b1110);
        run_cmd(2'b11, 5, 4'b1001, 1'b0, 1'b0, 1'b0);
        run_cmd(2'b10, 4, 0, 1'b0, 1'b1, 1'b0);
        chk("shl_rot4_value", data_out, 4'b1001);
        run_cmd(2'b00, 0, 4'b0110, 1'b1, 1'b0, 1'b0);
        chk("hold0_value", data_out, 4'b1001);
        run_cmd(2'b10, 2, 0, 1'b0, 1'b0, 1'b1);
        chk("single_done", done, 0);
        chk("shl_repulse_value", data_out, 4'b0100);
        run_cmd(2'b00, 3, 4'b1111, 1'b1, 1'b1, 1'b0);
        run_cmd(2'b01, 7, 0, 1'b1, 1'b0, 1'b0);
        chk("shr_overfill_value", data_out, 4'b1111);

        for (int i = 0; i < 30; i++) begin
            run_cmd(2'($urandom_range(0, 3)), int'($urandom_range(0, 7)),
                    int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        // Reset in the middle of a shift job discards it
        run_cmd(2'b11, 0, 4'b1111, 1'b0, 1'b0, 1'b0);
        cmd_valid = 1'b1;
        cmd_op    = 2'b01;
        cmd_cnt   = CNT_W'(4);
        cmd_fill  = 1'b0;
        cmd_rot   = 1'b0;
        next_cycle();
        cmd_valid = 1'b0;
        chk("mid_ser_out", ser_out, 1);
        next_cycle();
        chk("mid_data", data_out, 4'b0111);
        rst = 1'b1;
        next_cycle();
        rst   = 1'b0;
        m_val = 0;
        chk("mid_rst_data", data_out, 0);
        chk("mid_rst_ready", cmd_ready, 1);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        for (int k = 0; k < 5; k++) begin
            next_cycle();
            chk("post_rst_no_done", done, 0);
            chk("post_rst_data", data_out, 0);
        end
        run_cmd(2'b11, 0, 4'b0101, 1'b0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
